apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter sharing the single CPU-side port of the APB bridge among NUM_REQ requesters. Latches one requester's write/read command, issues it to the bridge as a one-cycle `trnsfr` pulse, waits for bridge completion, and returns read data and an acknowledge to the winning requester. Sits between CPU-side masters (or the test bench) and the bridge's address/data channel; one transfer is outstanding at a time.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- TIMEOUT, 16: completion-watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, held until its ack.
- req_wr  in  NUM_REQ  per-requester direction, 1 = write.
- req_dsel  in  2*NUM_REQ  per-requester byte/half-word/word select, 2 bits each, requester i at [2i+1:2i].
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i in slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid while ack is high.
- rsp_err  out  1  timeout flag, valid while ack is high.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last winner.
- busy  out  1  high in every state except IDLE.
- trnsfr  out  1  one-cycle transfer start to the bridge.
- wr  out  1  direction to the bridge.
- dsel  out  2  transfer size to the bridge.
- address  out  ADDR_WIDTH  address to the bridge.
- data_in  out  DATA_WIDTH  write data to the bridge.
- data_out  in  DATA_WIDTH  read data from the bridge.
- done  in  1  bridge completion pulse; data_out is valid in the same cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, select the winner by round-robin starting at pointer ptr: the first set bit at ptr, ptr+1, … mod NUM_REQ. Latch the winner's wr/dsel/addr/wdata into command registers, set grant_id, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: trnsfr=1 for exactly this cycle, then go to WAIT.
- WAIT: trnsfr=0. Bus fields stay at the latched values. On done=1, capture data_out into rsp_rdata (writes capture as well; requester ignores it), rsp_err=0, and go to RESP.
- RESP: ack[grant_id]=1 for one cycle, ptr=(grant_id+1) mod NUM_REQ, then go to IDLE.
- wr/dsel/address/data_in come only from the command registers and are stable from ISSUE through RESP. Requester inputs do not affect the bus after latching.
- Requester deasserts req in the cycle after ack. req sampled high in IDLE is always a new request.
- req dropped before ack: the transfer still completes and ack still pulses.
- done outside WAIT is ignored.
- rsp_rdata and rsp_err hold their values until the next capture.
- Reset, including mid-transfer: state=IDLE, ptr=0, all outputs 0 (ack, rsp_rdata, rsp_err, grant_id, busy, trnsfr, wr, dsel, address, data_in). The in-flight transfer is abandoned with no ack.

## Timing
- Request seen in IDLE at cycle 0 → trnsfr at cycle 1 → done at earliest cycle 2 → ack at cycle 3 → IDLE at cycle 4.
- Minimum 4 cycles per transfer. Back-to-back grants have 1 idle cycle between ack and the next trnsfr+1.
- Fairness: with all requesters continuously requesting, each is granted once per NUM_REQ transfers.
- No combinational path from req or done to any output; all outputs are registered.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If done is not seen by TIMEOUT cycles in WAIT, go to RESP with rsp_err=1 and rsp_rdata=0.
  - done in the expiry cycle wins: normal response, rsp_err=0.
- ARB_TIMEOUT_EN undefined: no counter, WAIT lasts until done, rsp_err is tied 0.

## Test plan
- Single read: req[2]=1, addr 0x10, dsel 2'b10, done after 3 WAIT cycles with data_out 0xDEADBEEF → trnsfr once, address 0x10, ack[2] pulse, rsp_rdata 0xDEADBEEF, rsp_err 0.
- Round-robin: req=4'b1111 held, done 1 cycle after each trnsfr → grant order 0,1,2,3,0; each ack 4 cycles apart. Wrap: ptr=3 with req=4'b1001 → grants 3 then 0.
- Bus stability: change req_addr[1] to 0xFF after grant → address stays at the latched value through RESP.
- Reset mid-WAIT: assert rst_n=0 during WAIT → all outputs 0 immediately, no ack. After release, req[0] is granted first.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): done never asserted → ack at WAIT cycle 16 with rsp_err=1, rsp_rdata=0. done exactly at expiry → rsp_err=0.
- Early drop: req[1] falls in WAIT → transfer completes, ack[1] still pulses, and req[1] is not re-granted.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if
// Command/response channel between the request arbiter and the APB bridge.
//   master (arbiter side): drives trnsfr, wr, dsel, address, data_in;
//                          receives data_out, done.
//   slave  (bridge side) : the reverse.
// Signals:
//   trnsfr   - one-cycle transfer start
//   wr       - direction, 1 = write
//   dsel     - transfer size (byte/half-word/word)
//   address  - transfer address
//   data_in  - write data toward the bridge
//   data_out - read data from the bridge, valid with done
//   done     - one-cycle completion pulse from the bridge
interface apb_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  trnsfr;
    logic                  wr;
    logic [1:0]            dsel;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  done;

    modport master (
        output trnsfr, wr, dsel, address, data_in,
        input  data_out, done
    );

    modport slave (
        input  trnsfr, wr, dsel, address, data_in,
        output data_out, done
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Round-robin arbiter sharing the single CPU-side port of the APB bridge
// among NUM_REQ requesters. One transfer is outstanding at a time: the
// winner's command is latched, issued as a one-cycle trnsfr pulse, and the
// bridge's done is answered with a one-cycle ack to the winner.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   - WAIT gives up after TIMEOUT cycles without done and answers
//               with rsp_err=1, rsp_rdata=0 (done in the expiry cycle wins).
//   undefined - WAIT lasts until done, rsp_err is tied 0.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   req          - per-requester request, held until ack
//   req_wr       - per-requester direction, 1 = write
//   req_dsel     - per-requester size, requester i at [2i+1:2i]
//   req_addr     - flattened addresses, requester i in slice i
//   req_wdata    - flattened write data, requester i in slice i
//   ack          - one-hot one-cycle completion pulse
//   rsp_rdata    - read data, valid while ack is high, held otherwise
//   rsp_err      - timeout flag, valid while ack is high
//   grant_id     - index of the current or last winner
//   busy         - high in every state except IDLE
//   bus          - bridge channel (master modport)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; pick a winner round-robin from ptr
// ISSUE | trnsfr high for this single cycle
// WAIT  | command held on the bus, waiting for done (or timeout)
// RESP  | ack to the winner, advance ptr past it
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [2*NUM_REQ-1:0]          req_dsel,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    apb_req_arbiter_if.master             bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("apb_req_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_req_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;

    // Per-requester views of the flattened command buses.
    logic [1:0]            dsel_arr  [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dsel_arr[g]  = req_dsel[2*g +: 2];
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first set request at ptr, ptr+1, ... mod NUM_REQ.
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] rr_id;
    logic            win_found;
    int              rr_idx;

    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        rr_idx    = 0;
        rr_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(ptr) + k) % NUM_REQ;
            rr_id  = ID_W'(rr_idx);
            if (!win_found && req[rr_id]) begin
                win_found = 1'b1;
                win_id    = rr_id;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            ack         <= '0;
            rsp_rdata   <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            bus.trnsfr  <= 1'b0;
            bus.wr      <= 1'b0;
            bus.dsel    <= '0;
            bus.address <= '0;
            bus.data_in <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        bus.wr      <= req_wr[win_id];
                        bus.dsel    <= dsel_arr[win_id];
                        bus.address <= addr_arr[win_id];
                        bus.data_in <= wdata_arr[win_id];
                        grant_id    <= win_id;
                        bus.trnsfr  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.trnsfr <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.done) begin
                        rsp_rdata     <= bus.data_out;
`ifdef ARB_TIMEOUT_EN
                        rsp_err_q     <= 1'b0;
`endif
                        ack[grant_id] <= 1'b1;
                        state         <= ST_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    // wait_cnt equals TIMEOUT-1 in the TIMEOUT-th WAIT cycle.
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_rdata     <= '0;
                        rsp_err_q     <= 1'b1;
                        ack[grant_id] <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (grant_id == ID_W'(NUM_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_id + 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    bus.trnsfr <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
// Table of request vectors applied in sequence; each vector's expected
// response is pushed to a scoreboard when driven and popped when ack fires.
// Hand-written sequences cover reset mid-WAIT and the start-up reset state.
module tb_apb_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_wr = '0;
    logic [2*N-1:0]  req_dsel = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            busy;

    apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_wr    (req_wr),
        .req_dsel  (req_dsel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .grant_id  (grant_id),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // lag: cycles from the trnsfr cycle to the done cycle; 0 = never done.
    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  wr;
        logic [AW-1:0] base;
        int            lag;
        logic [DW-1:0] rdata;
        int            exp_id;
        bit            drop;
    } vec_t;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        logic [1:0]    dsel;
        logic [DW-1:0] rdata;
        logic          err;
        int            ack_cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},       64'(ack),         64'd0);
        chk({tag, "_rdata"},     64'(rsp_rdata),   64'd0);
        chk({tag, "_err"},       64'(rsp_err),     64'd0);
        chk({tag, "_grant_id"},  64'(grant_id),    64'd0);
        chk({tag, "_busy"},      64'(busy),        64'd0);
        chk({tag, "_trnsfr"},    64'(bus.trnsfr),  64'd0);
        chk({tag, "_wr"},        64'(bus.wr),      64'd0);
        chk({tag, "_dsel"},      64'(bus.dsel),    64'd0);
        chk({tag, "_address"},   64'(bus.address), 64'd0);
        chk({tag, "_data_in"},   64'(bus.data_in), 64'd0);
    endtask

    // Requester i: address base+4i, write data ~address, size i[1:0].
    task automatic drive_reqs(input logic [N-1:0] r, input logic [N-1:0] w, input logic [AW-1:0] base);
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = base + AW'(4 * i);
            req_wdata[i*DW +: DW] = ~(base + AW'(4 * i));
            req_dsel[2*i +: 2]    = 2'(i);
        end
        req_wr = w;
        req    = r;
    endtask

    task automatic scramble_reqs();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = 32'hFF;
            req_wdata[i*DW +: DW] = $urandom;
        end
        req_wr   = ~req_wr;
        req_dsel = ~req_dsel;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc;
        int   done_at;
        int   n_trn;
        bit   got;
        @(posedge clk);
        #1;
        drive_reqs(v.req, v.wr, v.base);
        e.id      = v.exp_id;
        e.addr    = v.base + AW'(4 * v.exp_id);
        e.wdata   = ~e.addr;
        e.wr      = v.wr[v.exp_id];
        e.dsel    = 2'(v.exp_id);
        e.err     = (v.lag == 0);
        e.rdata   = e.err ? '0 : v.rdata;
        e.ack_cyc = (v.lag == 0) ? TO + 2 : v.lag + 2;
        sb.push_back(e);
        // done in IDLE/ISSUE must be ignored; use junk data there.
        bus.done     = (v.lag >= 2);
        bus.data_out = $urandom;
        cyc     = 0;
        done_at = -1;
        n_trn   = 0;
        got     = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (cyc == 0) begin
                chk("idle_busy",   64'(busy),       64'd0);
                chk("idle_trnsfr", 64'(bus.trnsfr), 64'd0);
                chk("idle_ack",    64'(ack),        64'd0);
            end
            if (cyc == 1) chk("trnsfr_latency", 64'(bus.trnsfr), 64'd1);
            if (bus.trnsfr) begin
                n_trn++;
                if (v.lag > 0) done_at = cyc + v.lag;
                chk("issue_grant_id", 64'(grant_id),    64'(sb[0].id));
                chk("issue_address",  64'(bus.address), 64'(sb[0].addr));
                chk("issue_data_in",  64'(bus.data_in), 64'(sb[0].wdata));
                chk("issue_wr",       64'(bus.wr),      64'(sb[0].wr));
                chk("issue_dsel",     64'(bus.dsel),    64'(sb[0].dsel));
            end
            if (ack != '0) begin
                got = 1'b1;
                e = sb.pop_front();
                chk("ack_onehot",   64'(ack),         64'(1) << e.id);
                chk("ack_cycle",    64'(cyc),         64'(e.ack_cyc));
                chk("rsp_rdata",    64'(rsp_rdata),   64'(e.rdata));
                chk("rsp_err",      64'(rsp_err),     64'(e.err));
                chk("grant_id",     64'(grant_id),    64'(e.id));
                chk("resp_address", 64'(bus.address), 64'(e.addr));
                chk("resp_data_in", 64'(bus.data_in), 64'(e.wdata));
                chk("resp_wr",      64'(bus.wr),      64'(e.wr));
                chk("resp_dsel",    64'(bus.dsel),    64'(e.dsel));
                chk("resp_busy",    64'(busy),        64'd1);
                chk("trnsfr_count", 64'(n_trn),       64'd1);
            end else begin
                @(posedge clk);
                #1;
                bus.done     = (cyc + 1 == done_at) || (cyc + 1 == 1 && v.lag >= 2);
                bus.data_out = (cyc + 1 == done_at) ? v.rdata : DW'($urandom);
                if (cyc + 1 == 2) begin
                    scramble_reqs();
                    if (v.drop) req[v.exp_id] = 1'b0;
                end
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no ack within %0d cycles, expected ack[%0d]", cyc, v.exp_id);
            e = sb.pop_front();
        end
        bus.done = 1'b0;
    endtask

    initial begin
        vec_t rv;
        int   wait_n;
        // req, wr, base, lag, rdata, exp_id, drop   (ptr starts at 0)
        vecs.push_back(vec_t'{4'b0100, 4'b0000, 32'h08,  3,  32'hDEADBEEF, 2, 1'b0}); // ptr->3
        vecs.push_back(vec_t'{4'b1001, 4'b1001, 32'h20,  1,  32'h11111111, 3, 1'b0}); // ptr->0
        vecs.push_back(vec_t'{4'b1001, 4'b0000, 32'h40,  1,  32'h22222222, 0, 1'b0}); // ptr->1
        vecs.push_back(vec_t'{4'b1111, 4'b0101, 32'h60,  1,  32'h33333333, 1, 1'b0}); // ptr->2
        vecs.push_back(vec_t'{4'b1111, 4'b0000, 32'h80,  1,  32'h44444444, 2, 1'b0}); // ptr->3
        vecs.push_back(vec_t'{4'b1111, 4'b1111, 32'hA0,  1,  32'h55555555, 3, 1'b0}); // ptr->0
        vecs.push_back(vec_t'{4'b1111, 4'b0000, 32'hC0,  1,  32'h66666666, 0, 1'b0}); // ptr->1
        vecs.push_back(vec_t'{4'b0110, 4'b0010, 32'hE0,  4,  32'h77777777, 1, 1'b1}); // ptr->2
        vecs.push_back(vec_t'{4'b0100, 4'b0000, 32'h100, 2,  32'h88888888, 2, 1'b0}); // ptr->3
        vecs.push_back(vec_t'{4'b0011, 4'b0001, 32'h120, 16, 32'h99999999, 0, 1'b0}); // ptr->1
`ifdef ARB_TIMEOUT_EN
        vecs.push_back(vec_t'{4'b0010, 4'b0000, 32'h140, 0,  32'hAAAAAAAA, 1, 1'b0}); // ptr->2
`endif

        bus.done     = 1'b0;
        bus.data_out = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of WAIT: abandon the transfer, no ack.
        @(posedge clk);
        #1;
        drive_reqs(4'b1110, 4'b1110, 32'h300);
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!bus.trnsfr && wait_n < 10);
        if (!bus.trnsfr) begin
            checks++;
            errors++;
            $display("FAIL midreset_trnsfr: no trnsfr within %0d cycles", wait_n);
        end
        @(negedge clk);
        chk("midreset_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midreset_no_ack", 64'(ack), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ptr is back at 0 after reset, so requester 0 wins first.
        rv = vec_t'{4'b1111, 4'b1010, 32'h400, 2, 32'h0BADF00D, 0, 1'b0};
        run_vec(rv);

        @(posedge clk);
        #1;
        req = '0;
        repeat (6) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
